// File: rtl/mmio_uart_tx_if.sv
// Store/load bus between the MEM stage and the memory-mapped UART transmitter.
interface mmio_uart_tx_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sel;
    logic [31:0] rdata;

    modport master (output we, addr, wdata, input sel, rdata);
    modport slave  (input we, addr, wdata, output sel, rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: stores to TXDATA queue bytes in a small FIFO,
// a bit-timed serializer drains it onto tx; STATUS and DIVISOR let software pace the link.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_00C0,
    parameter int unsigned DEPTH       = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic          clock,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [7:0]       fifo_q [DEPTH];
    logic [7:0]       fifo_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      divisor_q, divisor_d;
    logic [15:0]      div_lat_q, div_lat_d;
    logic [15:0]      timer_q, timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic [1:0]  offset;
    logic        wr_txdata, wr_status, wr_divisor;
    logic        fifo_empty, fifo_full, pop, push_ok, timer_done;
    logic [15:0] eff_div;
    logic [2:0]  count3;
    logic        unused_bits;

    assign offset      = bus.addr[3:2];
    assign bus.sel     = (bus.addr[31:4] == BASE_ADDR[31:4]) && (offset != 2'd3);
    assign wr_txdata   = bus.we && bus.sel && (offset == 2'd0);
    assign wr_status   = bus.we && bus.sel && (offset == 2'd1);
    assign wr_divisor  = bus.we && bus.sel && (offset == 2'd2);
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:16]};

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign pop        = (state_q == IDLE) && !fifo_empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign push_ok    = wr_txdata && (!fifo_full || pop);
    assign eff_div    = (divisor_q == 16'd0) ? 16'd1 : divisor_q;
    assign timer_done = (timer_q == div_lat_q - 16'd1);
    assign count3     = 3'(count_q);

    assign busy = (state_q != IDLE) || !fifo_empty;
    assign tx   = tx_q;

    always_comb begin
        bus.rdata = 32'h0;
        if (bus.sel) begin
            case (offset)
                2'd1:    bus.rdata = {25'b0, ovf_q, count3, fifo_empty, fifo_full, busy};
                2'd2:    bus.rdata = {16'b0, divisor_q};
                default: bus.rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        divisor_d = divisor_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = bus.wdata[7:0];
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        if (wr_status && bus.wdata[6]) begin
            ovf_d = 1'b0;
        end
        if (wr_txdata && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (wr_divisor) begin
            divisor_d = bus.wdata[15:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!fifo_empty) state_d = START;
            START: if (timer_done) state_d = DATA;
            DATA:  if (timer_done && bit_idx_q == 3'd7) state_d = STOP;
            STOP:  if (timer_done) state_d = IDLE;
        endcase
    end

    // The divisor is latched at the start bit so a mid-frame DIVISOR write waits for the next frame.
    always_comb begin
        tx_d      = tx_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        div_lat_d = div_lat_q;
        case (state_q)
            IDLE: begin
                tx_d    = 1'b1;
                timer_d = 16'd0;
                if (pop) begin
                    shift_d   = fifo_q[rd_ptr_q];
                    tx_d      = 1'b0;
                    div_lat_d = eff_div;
                end
            end
            START: begin
                if (timer_done) begin
                    timer_d   = 16'd0;
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            DATA: begin
                if (timer_done) begin
                    timer_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            STOP: begin
                tx_d    = 1'b1;
                timer_d = timer_done ? 16'd0 : timer_q + 16'd1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= 8'h00;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            divisor_q <= DEFAULT_DIV;
            div_lat_q <= 16'd1;
            timer_q   <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            divisor_q <= divisor_d;
            div_lat_q <= div_lat_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule
